// File: rtl/uart_tx.sv
// uart_tx: 8N1-style serial transmitter with ready/new_data handshake; optional even parity via UART_PARITY_EN
module uart_tx #(
    parameter int DATA_BITS = 8,
    parameter int BAUD      = 9600,
    parameter int SYS_CLK   = 12000000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 enable,
    input  logic [DATA_BITS-1:0] tx_input,
    input  logic                 new_data,
    output logic                 tx_wire,
    output logic                 ready
);
    localparam int DIV = (SYS_CLK + BAUD / 2) / BAUD;
    localparam int CW  = DIV > 1 ? $clog2(DIV) : 1;
    localparam int BW  = DATA_BITS > 1 ? $clog2(DATA_BITS) : 1;
    localparam logic [CW-1:0] BAUD_LAST = CW'(DIV - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t               r_state, w_state;
    logic [CW-1:0]        r_baud, w_baud;
    logic [BW-1:0]        r_bit, w_bit;
    logic [DATA_BITS-1:0] r_shift, w_shift;
    logic                 r_tx, w_tx;
    logic                 w_bit_end;
`ifdef UART_PARITY_EN
    logic                 r_par, w_par;
`endif

    assign w_bit_end = r_baud == BAUD_LAST;
    assign ready     = (r_state == IDLE) && enable;
    assign tx_wire   = r_tx;

    // Next-state logic: baud counter wraps every bit; the shift register drops one bit per data bit
    always_comb begin
        w_state = r_state;
        w_baud  = w_bit_end ? '0 : r_baud + CW'(1);
        w_bit   = r_bit;
        w_shift = r_shift;
        w_tx    = r_tx;
`ifdef UART_PARITY_EN
        w_par   = r_par;
`endif
        if (!enable) begin
            w_state = IDLE;
            w_tx    = 1'b1;
            w_baud  = '0;
            w_bit   = '0;
        end else begin
            case (r_state)
                IDLE: begin
                    w_baud = '0;
                    w_bit  = '0;
                    if (new_data) begin
                        w_state = START;
                        w_tx    = 1'b0;
                        w_shift = tx_input;
`ifdef UART_PARITY_EN
                        w_par   = ^tx_input;
`endif
                    end
                end
                START: begin
                    w_state = w_bit_end ? DATA : START;
                    w_tx    = w_bit_end ? r_shift[0] : r_tx;
                end
                DATA: begin
                    if (w_bit_end && r_bit == BIT_LAST) begin
`ifdef UART_PARITY_EN
                        w_state = PARITY;
                        w_tx    = r_par;
`else
                        w_state = STOP;
                        w_tx    = 1'b1;
`endif
                    end else if (w_bit_end) begin
                        w_bit   = r_bit + BW'(1);
                        w_shift = r_shift >> 1;
                        w_tx    = w_shift[0];
                    end
                end
                PARITY: begin
                    w_state = w_bit_end ? STOP : PARITY;
                    w_tx    = w_bit_end ? 1'b1 : r_tx;
                end
                STOP: w_state = w_bit_end ? IDLE : STOP;
                default: begin
                    w_state = IDLE;
                    w_tx    = 1'b1;
                end
            endcase
        end
    end

    // State register; reset forces the line idle-high at once, independent of clk
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_baud  <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_tx    <= 1'b1;
`ifdef UART_PARITY_EN
            r_par   <= 1'b0;
`endif
        end else begin
            r_state <= w_state;
            r_baud  <= w_baud;
            r_bit   <= w_bit;
            r_shift <= w_shift;
            r_tx    <= w_tx;
`ifdef UART_PARITY_EN
            r_par   <= w_par;
`endif
        end
    end
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: randomized scoreboard bench for uart_tx; honours UART_PARITY_EN
module tb_uart_tx;
    localparam int DATA_BITS = 8;
    localparam int BAUD      = 1000000;
    localparam int SYS_CLK   = 8000000;
    localparam int DIV       = (SYS_CLK + BAUD / 2) / BAUD;
`ifdef UART_PARITY_EN
    localparam int NB = DATA_BITS + 3;
`else
    localparam int NB = DATA_BITS + 2;
`endif
    localparam int F = NB * DIV;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 enable = 1'b1;
    logic [DATA_BITS-1:0] tx_input = '0;
    logic                 new_data = 1'b0;
    logic                 tx_wire;
    logic                 ready;

    int passed = 0;
    int total  = 0;
    int cyc    = 0;
    int t0     = 0;
    bit mon_en = 1'b1;
    logic [NB-1:0] q[$];

    uart_tx #(.DATA_BITS(DATA_BITS), .BAUD(BAUD), .SYS_CLK(SYS_CLK)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .tx_input(tx_input),
        .new_data(new_data), .tx_wire(tx_wire), .ready(ready)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Expected line sequence in transmit order: start 0, data LSB first, optional even parity, stop 1
    function automatic logic [NB-1:0] frame_bits(input logic [DATA_BITS-1:0] d);
        logic [NB-1:0] b;
        b[0] = 1'b0;
        for (int i = 0; i < DATA_BITS; i++) b[i+1] = d[i];
`ifdef UART_PARITY_EN
        b[DATA_BITS+1] = ^d;
`endif
        b[NB-1] = 1'b1;
        return b;
    endfunction

    // Monitor: on each start edge, pop the expected frame and sample every bit mid-period
    initial forever begin
        logic [NB-1:0] e;
        @(negedge tx_wire);
        if (mon_en && rst_n) begin
            if (q.size() == 0) chk("unexpected_frame", 1, 0);
            else begin
                e = q.pop_front();
                for (int i = 0; i < NB; i++) begin
                    repeat (i == 0 ? DIV / 2 : DIV) @(posedge clk);
                    @(negedge clk);
                    chk($sformatf("frame_bit%0d", i), int'(tx_wire), int'(e[i]));
                end
            end
        end
    end

    task automatic send(input logic [DATA_BITS-1:0] d, input bit push);
        int n = 0;
        @(negedge clk);
        while (!ready && n < 4 * F) begin
            @(negedge clk);
            n++;
        end
        chk("ready_before_send", int'(ready), 1);
        tx_input = d;
        new_data = 1'b1;
        if (push) q.push_back(frame_bits(d));
        @(posedge clk);
        #1;
        t0 = cyc;
        new_data = 1'b0;
        tx_input = DATA_BITS'($urandom);
        chk("start_latency", int'(tx_wire), 0);
        chk("ready_fall", int'(ready), 0);
    endtask

    task automatic finish_frame();
        int n = 0;
        while (!ready && n < 2 * F) begin
            @(negedge clk);
            n++;
        end
        chk("frame_len", cyc - t0, F);
    endtask

    initial begin
        logic [DATA_BITS-1:0] d;
        #12;
        chk("reset_tx", int'(tx_wire), 1);
        chk("reset_ready", int'(ready), 1);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            repeat (DIV) @(negedge clk);
            chk("idle_tx", int'(tx_wire), 1);
            chk("idle_ready", int'(ready), 1);
        end
        foreach (q[i]) q.delete(i);
        send(8'h00, 1'b1); finish_frame();
        send(8'h81, 1'b1); finish_frame();
        send(8'hA5, 1'b1); finish_frame();
        send(8'hBE, 1'b1); finish_frame();
        send(8'h07, 1'b1); finish_frame();
        send(8'h03, 1'b1); finish_frame();
        for (int k = 0; k < 6; k++) begin
            send(DATA_BITS'($urandom), 1'b1);
            finish_frame();
        end
        // Back-to-back: new_data held high across two frames
        @(negedge clk);
        d = DATA_BITS'($urandom);
        tx_input = d;
        new_data = 1'b1;
        q.push_back(frame_bits(d));
        @(posedge clk);
        #1;
        t0 = cyc;
        chk("b2b_first_start", int'(tx_wire), 0);
        tx_input = DATA_BITS'($urandom);
        begin
            int n = 0;
            while (!ready && n < 2 * F) begin
                @(negedge clk);
                n++;
            end
        end
        chk("b2b_ready_rise", cyc - t0, F);
        d = DATA_BITS'($urandom);
        tx_input = d;
        q.push_back(frame_bits(d));
        @(posedge clk);
        #1;
        chk("b2b_second_start", cyc - t0, F + 1);
        chk("b2b_second_low", int'(tx_wire), 0);
        t0 = cyc;
        new_data = 1'b0;
        tx_input = DATA_BITS'($urandom);
        finish_frame();
        // Abort by dropping enable during data bit 3
        mon_en = 1'b0;
        send(8'hFF, 1'b0);
        repeat (4 * DIV + DIV / 2) @(posedge clk);
        @(negedge clk);
        enable = 1'b0;
        @(posedge clk);
        #1;
        chk("abort_tx", int'(tx_wire), 1);
        chk("abort_ready", int'(ready), 0);
        @(negedge clk);
        enable = 1'b1;
        #1;
        chk("reenable_ready", int'(ready), 1);
        repeat (2 * DIV) @(negedge clk);
        chk("abort_no_resume", int'(tx_wire), 1);
        mon_en = 1'b1;
        send(DATA_BITS'($urandom), 1'b1);
        finish_frame();
        // Asynchronous reset mid-frame
        mon_en = 1'b0;
        send(8'h00, 1'b0);
        repeat (3 * DIV) @(posedge clk);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset_tx", int'(tx_wire), 1);
        chk("async_reset_ready", int'(ready), 1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2 * DIV) @(negedge clk);
        chk("post_reset_idle", int'(tx_wire), 1);
        mon_en = 1'b1;
        send(8'h5A, 1'b1);
        finish_frame();
        repeat (2 * DIV) @(negedge clk);
        chk("scoreboard_drained", q.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
